lab3_g29_mux_arbiter: RTL

Four-requester round-robin arbiter that shares one 4-bit output channel among sources `a`, `b`, `c`, `d`. It sequences the 4:1 select (`sel`, 00=a, 01=b, 10=c, 11=d), registers the chosen word, and presents it downstream with a valid/ready handshake. It is the control layer in front of the lab's 4-bit 4:1 multiplexer datapath.

---
 rtl/lab3_g29_pkg.sv | 28 ++
 rtl/lab3_g29_mux4.sv | 24 ++
 rtl/lab3_g29_mux_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/lab3_g29_pkg.sv
// Shared types and constants for the lab3 g29 round-robin mux arbiter.
// Optional grant counters are enabled by defining LAB3_GRANT_CNT_EN.
package lab3_g29_pkg;
  localparam int NUM_SRC = 4;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  // First set request at or after ptr, wrapping modulo NUM_SRC.
  function automatic logic [1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                         input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/lab3_g29_mux4.sv
// Parameterized 4:1 combinational mux feeding the arbiter's output register.
module lab3_g29_mux4
  import lab3_g29_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = a;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = a;
    endcase
  end
endmodule

// File: rtl/lab3_g29_mux_arbiter.sv
// Four-source round-robin arbiter with registered valid/ready output.
// Define LAB3_GRANT_CNT_EN to add saturating per-source grant counters.
module lab3_g29_mux_arbiter
  import lab3_g29_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [WIDTH-1:0]                 a,
  input  logic [WIDTH-1:0]                 b,
  input  logic [WIDTH-1:0]                 c,
  input  logic [WIDTH-1:0]                 d,
  input  logic [NUM_SRC-1:0]               req,
  output logic [NUM_SRC-1:0]               ack,
  output logic [1:0]                       sel,
  output logic [WIDTH-1:0]                 y,
  output logic                             y_valid,
`ifdef LAB3_GRANT_CNT_EN
  output logic [NUM_SRC-1:0][CNT_W-1:0]    grant_cnt,
`endif
  input  logic                             y_ready
);
  arb_state_t       state;
  logic [1:0]       ptr;
  logic [1:0]       win;
  logic [WIDTH-1:0] mux_y;
  logic             xfer;

  assign win  = rr_pick(req, ptr);
  assign xfer = (state == BUSY) && y_valid && y_ready;

  lab3_g29_mux4 #(.WIDTH(WIDTH)) u_mux (
    .a(a), .b(b), .c(c), .d(d), .sel(win), .y(mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= SEL_A;
      sel     <= SEL_A;
      y       <= '0;
      y_valid <= 1'b0;
      ack     <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (|req) begin
          sel     <= win;
          y       <= mux_y;
          y_valid <= 1'b1;
          state   <= BUSY;
        end
        BUSY: if (xfer) begin
          ack[sel] <= 1'b1;
          y_valid  <= 1'b0;
          ptr      <= sel + 2'd1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LAB3_GRANT_CNT_EN
  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (xfer) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (sel == 2'(i) && grant_cnt[i] != {CNT_W{1'b1}})
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
    end
  end
`endif
endmodule
